// File: rtl/cp0_exc_seq_pkg.sv
// Shared constants for the CP0 exception sequencer: ExcCodes, excepttype bit
// positions, CP0 register addresses and the sequencer state encoding.
package cp0_exc_seq_pkg;

   localparam logic [4:0] EXC_INT = 5'd0;
   localparam logic [4:0] EXC_SYS = 5'd8;
   localparam logic [4:0] EXC_RI  = 5'd10;
   localparam logic [4:0] EXC_OV  = 5'd12;
   localparam logic [4:0] EXC_TR  = 5'd13;

   localparam int ET_SYS  = 8;
   localparam int ET_RI   = 9;
   localparam int ET_TR   = 10;
   localparam int ET_OV   = 11;
   localparam int ET_ERET = 12;

   localparam logic [4:0] CP0_STATUS = 5'd12;
   localparam logic [4:0] CP0_CAUSE  = 5'd13;
   localparam logic [4:0] CP0_EPC    = 5'd14;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WR_EPC    = 3'd1,
      S_WR_CAUSE  = 3'd2,
      S_WR_STATUS = 3'd3,
      S_ERET_ST   = 3'd4,
      S_REDIRECT  = 3'd5
   } state_t;

endpackage

// File: rtl/cp0_exc_seq_if.sv
// CP0 write-side bus: incoming mtc0 write request and the arbitrated CP0 write port.
interface cp0_exc_seq_if;
   logic        mtc0_we_i;
   logic [4:0]  mtc0_waddr_i;
   logic [31:0] mtc0_data_i;
   logic        cp0_we_o;
   logic [4:0]  cp0_waddr_o;
   logic [31:0] cp0_data_o;
   logic        exc_wr_o;

   modport master (
      input  mtc0_we_i, mtc0_waddr_i, mtc0_data_i,
      output cp0_we_o, cp0_waddr_o, cp0_data_o, exc_wr_o
   );

   modport slave (
      output mtc0_we_i, mtc0_waddr_i, mtc0_data_i,
      input  cp0_we_o, cp0_waddr_o, cp0_data_o, exc_wr_o
   );
endinterface

// File: rtl/cp0_exc_seq_prio.sv
// Combinational exception arbitration: effective CP0 values, interrupt pending
// (only with CP0_EXC_INT_EN defined) and the priority-encoded ExcCode / eret select.
module cp0_exc_prio
   import cp0_exc_seq_pkg::*;
(
   input  logic [31:0] excepttype_i,
   input  logic [31:0] inst_addr_i,
   input  logic        mtc0_we_i,
   input  logic [4:0]  mtc0_waddr_i,
   input  logic [31:0] mtc0_data_i,
   input  logic [31:0] status_i,
   input  logic [31:0] cause_i,
   input  logic [31:0] epc_i,
   output logic [31:0] eff_status,
   output logic [31:0] eff_epc,
   output logic        exc_valid,
   output logic        eret_sel,
   output logic [4:0]  exc_code
);
   logic int_pending;

   // A same-cycle mtc0 to Status/EPC/Cause is what the next instruction would see
   assign eff_status = (mtc0_we_i && mtc0_waddr_i == CP0_STATUS) ? mtc0_data_i : status_i;
   assign eff_epc    = (mtc0_we_i && mtc0_waddr_i == CP0_EPC)    ? mtc0_data_i : epc_i;

`ifdef CP0_EXC_INT_EN
   logic [7:0] eff_ip;
   logic       unused_bits;
   assign eff_ip = (mtc0_we_i && mtc0_waddr_i == CP0_CAUSE) ? mtc0_data_i[15:8] : cause_i[15:8];
   assign int_pending = eff_status[0] && !eff_status[1] &&
                        ((eff_ip & eff_status[15:8]) != 8'd0) && (inst_addr_i != 32'd0);
   assign unused_bits = ^{excepttype_i[31:13], excepttype_i[7:0], cause_i[31:16], cause_i[7:0]};
`else
   logic unused_bits;
   assign int_pending = 1'b0;
   assign unused_bits = ^{excepttype_i[31:13], excepttype_i[7:0], cause_i, inst_addr_i};
`endif

   always_comb begin
      exc_valid = 1'b1;
      eret_sel  = 1'b0;
      exc_code  = EXC_INT;
      if (int_pending)                exc_code = EXC_INT;
      else if (excepttype_i[ET_SYS])  exc_code = EXC_SYS;
      else if (excepttype_i[ET_RI])   exc_code = EXC_RI;
      else if (excepttype_i[ET_TR])   exc_code = EXC_TR;
      else if (excepttype_i[ET_OV])   exc_code = EXC_OV;
      else begin
         exc_valid = 1'b0;
         eret_sel  = excepttype_i[ET_ERET];
      end
   end
endmodule

// File: rtl/cp0_exc_seq.sv
// CP0 exception/interrupt sequencer: arbitrates the CP0 write port between mtc0
// and the EPC/Cause/Status hardware update, then flushes and redirects the PC.
// Interrupt detection is compiled in only when CP0_EXC_INT_EN is defined.
module cp0_exc_seq
   import cp0_exc_seq_pkg::*;
#(
   parameter logic [31:0] HANDLER_PC = 32'h0000_0020
)(
   input  logic               clk,
   input  logic               rst,
   input  logic [31:0]        excepttype_i,
   input  logic [31:0]        inst_addr_i,
   input  logic               is_in_delayslot_i,
   input  logic [31:0]        status_i,
   input  logic [31:0]        cause_i,
   input  logic [31:0]        epc_i,
   cp0_exc_seq_if.master      wr,
   output logic               stall_o,
   output logic               flush_o,
   output logic [31:0]        new_pc_o
);
   state_t      state_reg, state_next;
   logic [4:0]  code_reg, code_next;
   logic [31:0] epc_reg, epc_next;
   logic [31:0] status_reg, status_next;
   logic        bd_reg, bd_next;
   logic        eret_reg, eret_next;

   logic [31:0] eff_status, eff_epc;
   logic        exc_valid, eret_sel;
   logic [4:0]  exc_code;
   logic        unused_bits;

   assign unused_bits = ^{cause_i[31], cause_i[6:0]};

   cp0_exc_prio u_prio (
      .excepttype_i (excepttype_i),
      .inst_addr_i  (inst_addr_i),
      .mtc0_we_i    (wr.mtc0_we_i),
      .mtc0_waddr_i (wr.mtc0_waddr_i),
      .mtc0_data_i  (wr.mtc0_data_i),
      .status_i     (status_i),
      .cause_i      (cause_i),
      .epc_i        (epc_i),
      .eff_status   (eff_status),
      .eff_epc      (eff_epc),
      .exc_valid    (exc_valid),
      .eret_sel     (eret_sel),
      .exc_code     (exc_code)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg  <= S_IDLE;
         code_reg   <= 5'd0;
         epc_reg    <= 32'd0;
         status_reg <= 32'd0;
         bd_reg     <= 1'b0;
         eret_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         code_reg   <= code_next;
         epc_reg    <= epc_next;
         status_reg <= status_next;
         bd_reg     <= bd_next;
         eret_reg   <= eret_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      code_next   = code_reg;
      epc_next    = epc_reg;
      status_next = status_reg;
      bd_next     = bd_reg;
      eret_next   = eret_reg;
      wr.cp0_we_o    = 1'b0;
      wr.cp0_waddr_o = 5'd0;
      wr.cp0_data_o  = 32'd0;
      wr.exc_wr_o    = 1'b0;
      stall_o        = 1'b0;
      flush_o        = 1'b0;
      new_pc_o       = 32'd0;

      case (state_reg)
         S_IDLE: begin
            if (exc_valid) begin
               // Faulting instruction does not commit, so its mtc0 is dropped
               code_next   = exc_code;
               epc_next    = is_in_delayslot_i ? inst_addr_i - 32'd4 : inst_addr_i;
               bd_next     = is_in_delayslot_i;
               status_next = eff_status;
               eret_next   = 1'b0;
               state_next  = S_WR_EPC;
               stall_o     = 1'b1;
            end else if (eret_sel) begin
               epc_next    = eff_epc;
               status_next = eff_status;
               eret_next   = 1'b1;
               state_next  = S_ERET_ST;
               stall_o     = 1'b1;
            end else begin
               wr.cp0_we_o    = wr.mtc0_we_i;
               wr.cp0_waddr_o = wr.mtc0_waddr_i;
               wr.cp0_data_o  = wr.mtc0_data_i;
            end
         end
         S_WR_EPC: begin
            wr.cp0_we_o    = 1'b1;
            wr.cp0_waddr_o = CP0_EPC;
            wr.cp0_data_o  = epc_reg;
            wr.exc_wr_o    = 1'b1;
            stall_o        = 1'b1;
            state_next     = S_WR_CAUSE;
         end
         S_WR_CAUSE: begin
            wr.cp0_we_o    = 1'b1;
            wr.cp0_waddr_o = CP0_CAUSE;
            wr.cp0_data_o  = {bd_reg, cause_i[30:7], code_reg, 2'b00};
            wr.exc_wr_o    = 1'b1;
            stall_o        = 1'b1;
            state_next     = S_WR_STATUS;
         end
         S_WR_STATUS: begin
            wr.cp0_we_o    = 1'b1;
            wr.cp0_waddr_o = CP0_STATUS;
            wr.cp0_data_o  = status_reg | 32'h2;
            wr.exc_wr_o    = 1'b1;
            stall_o        = 1'b1;
            state_next     = S_REDIRECT;
         end
         S_ERET_ST: begin
            wr.cp0_we_o    = 1'b1;
            wr.cp0_waddr_o = CP0_STATUS;
            wr.cp0_data_o  = status_reg & ~32'h2;
            wr.exc_wr_o    = 1'b1;
            stall_o        = 1'b1;
            state_next     = S_REDIRECT;
         end
         S_REDIRECT: begin
            flush_o    = 1'b1;
            new_pc_o   = eret_reg ? epc_reg : HANDLER_PC;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase

      // Outputs are silent for the whole time reset is held
      if (!rst) begin
         wr.cp0_we_o    = 1'b0;
         wr.cp0_waddr_o = 5'd0;
         wr.cp0_data_o  = 32'd0;
         wr.exc_wr_o    = 1'b0;
         stall_o        = 1'b0;
         flush_o        = 1'b0;
         new_pc_o       = 32'd0;
      end
   end
endmodule
